// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: the indirect (LDI/STI) memory sequence states.
package lc3b_types;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IND_PTR  = 2'd1,
        IND_DATA = 2'd2
    } ind_state_t;

endpackage

// File: rtl/indirect_fsm.sv
// Two-phase LDI/STI sequencer: pointer fetch followed by data access on the D-side.
module indirect_fsm
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dmem_req,
    input  logic       dmem_resp,
    input  logic       mem_indirect,
    output ind_state_t state,
    output logic       indirect_phase
);

    ind_state_t next_state;
    logic       mem_done;

    // A response only counts while a request is actually outstanding.
    assign mem_done = dmem_req & dmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                // A same-cycle response is the pointer, so single-cycle memory skips IND_PTR.
                if (mem_indirect && dmem_req) begin
                    next_state = mem_done ? IND_DATA : IND_PTR;
                end
            end
            IND_PTR: begin
                if (mem_done) begin
                    next_state = IND_DATA;
                end
            end
            IND_DATA: begin
                if (mem_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign indirect_phase = (state == IND_DATA);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer: merges memory, indirect, load-use and branch hazards.
module hazard_sequencer
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             mem_indirect,
    input  logic             load_use,
    input  logic             branch_taken,
    output logic             pc_load,
    output logic             flow_IFID,
    output logic             flow_IDEX,
    output logic             flow_EXMEM,
    output logic             flow_MEMWB,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             flush_EXMEM,
    output logic             indirect_phase,
    output logic [CNT_W-1:0] stall_count
);

    ind_state_t state;
    logic       mem_stall;
    logic       imem_wait;

    indirect_fsm u_indirect_fsm (
        .clk            (clk),
        .rst            (rst),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .mem_indirect   (mem_indirect),
        .state          (state),
        .indirect_phase (indirect_phase)
    );

    // The IDLE term freezes the pipe during the first pointer-fetch cycle.
    assign mem_stall = (dmem_req & ~dmem_resp)
                     | (state == IND_PTR)
                     | ((state == IDLE) & mem_indirect & dmem_req);
    assign imem_wait = imem_read & ~imem_resp;

    always_comb begin
        pc_load     = 1'b1;
        flow_IFID   = 1'b1;
        flow_IDEX   = 1'b1;
        flow_EXMEM  = 1'b1;
        flow_MEMWB  = 1'b1;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_EXMEM = 1'b0;
        if (rst) begin
            pc_load     = 1'b0;
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
        end else if (mem_stall) begin
            pc_load    = 1'b0;
            flow_IFID  = 1'b0;
            flow_IDEX  = 1'b0;
            flow_EXMEM = 1'b0;
            flow_MEMWB = 1'b0;
        end else if (branch_taken) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
        end else begin
            if (imem_wait) begin
                pc_load    = 1'b0;
                flush_IFID = 1'b1;
            end
            // Load-use holds IF/ID, which cancels the imem-wait bubble into it.
            if (load_use) begin
                pc_load    = 1'b0;
                flow_IFID  = 1'b0;
                flush_IFID = 1'b0;
                flush_IDEX = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!flow_MEMWB && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed hazard scenarios plus random traffic vs a reference model.
module tb_hazard_sequencer;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_read;
    logic             imem_resp;
    logic             dmem_req;
    logic             dmem_resp;
    logic             mem_indirect;
    logic             load_use;
    logic             branch_taken;
    logic             pc_load;
    logic             flow_IFID;
    logic             flow_IDEX;
    logic             flow_EXMEM;
    logic             flow_MEMWB;
    logic             flush_IFID;
    logic             flush_IDEX;
    logic             flush_EXMEM;
    logic             indirect_phase;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: an indirect op is in flight, and whether its pointer has arrived.
    bit m_in_op;
    bit m_ptr_done;
    int m_count;

    hazard_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_read      (imem_read),
        .imem_resp      (imem_resp),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .mem_indirect   (mem_indirect),
        .load_use       (load_use),
        .branch_taken   (branch_taken),
        .pc_load        (pc_load),
        .flow_IFID      (flow_IFID),
        .flow_IDEX      (flow_IDEX),
        .flow_EXMEM     (flow_EXMEM),
        .flow_MEMWB     (flow_MEMWB),
        .flush_IFID     (flush_IFID),
        .flush_IDEX     (flush_IDEX),
        .flush_EXMEM    (flush_EXMEM),
        .indirect_phase (indirect_phase),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    // Input order: {rst, imem_read, imem_resp, dmem_req, dmem_resp, mem_indirect, load_use, branch_taken}
    task automatic drive(input logic [7:0] v);
        {rst, imem_read, imem_resp, dmem_req, dmem_resp, mem_indirect, load_use, branch_taken} = v;
    endtask

    function automatic logic [8:0] dut_ctl();
        return {pc_load, flow_IFID, flow_IDEX, flow_EXMEM, flow_MEMWB,
                flush_IFID, flush_IDEX, flush_EXMEM, indirect_phase};
    endfunction

    function automatic bit model_frozen();
        bit waiting_data;
        bit ptr_outstanding;
        bit new_indirect;
        waiting_data    = dmem_req && !dmem_resp;
        ptr_outstanding = m_in_op && !m_ptr_done;
        new_indirect    = !m_in_op && mem_indirect && dmem_req;
        return !rst && (waiting_data || ptr_outstanding || new_indirect);
    endfunction

    function automatic logic [8:0] model_ctl();
        logic [7:0] c;
        c = 8'b1_1111_000;
        if (rst) begin
            c = 8'b0_1111_111;
        end else if (model_frozen()) begin
            c = 8'b0_0000_000;
        end else if (branch_taken) begin
            c = 8'b1_1111_111;
        end else if (load_use) begin
            c = 8'b0_0111_010;
        end else if (imem_read && !imem_resp) begin
            c = 8'b0_1111_100;
        end
        return {c, m_in_op && m_ptr_done};
    endfunction

    task automatic advance();
        bit frozen;
        bit done;
        frozen = model_frozen();
        done   = dmem_req && dmem_resp;
        @(posedge clk);
        if (rst) begin
            m_in_op    = 0;
            m_ptr_done = 0;
            m_count    = 0;
        end else begin
            if (!m_in_op) begin
                if (mem_indirect && dmem_req) begin
                    m_in_op    = 1;
                    m_ptr_done = done;
                end
            end else if (!m_ptr_done) begin
                if (done) m_ptr_done = 1;
            end else if (done) begin
                m_in_op    = 0;
                m_ptr_done = 0;
            end
            if (frozen && m_count < CNT_MAX) m_count++;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(8'b1000_0000);
        advance();
        drive(8'b0000_0000);
    endtask

    task automatic test_reset();
        drive(8'b1110_1011);
        advance();
        @(negedge clk);
        checks++;
        if (dut_ctl() !== 9'b0_1111_111_0) begin
            errors++;
            $display("[TB] FAIL reset_row got=%b want=%b", dut_ctl(), 9'b0_1111_111_0);
        end
        checks++;
        if (stall_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count got=%0d want=0", stall_count);
        end
        drive(8'b0000_0000);
        advance();
    endtask

    task automatic test_plain_load();
        logic [2:0] want_flow;
        logic [2:0] got_flow;
        do_reset();
        want_flow = 3'b001;
        for (int i = 0; i < 3; i++) begin
            drive((i == 2) ? 8'b0001_1000 : 8'b0001_0000);
            @(negedge clk);
            got_flow[2-i] = flow_MEMWB;
            checks++;
            if (dut_ctl() !== model_ctl()) begin
                errors++;
                $display("[TB] FAIL ldr_ctl cyc=%0d got=%b want=%b", i, dut_ctl(), model_ctl());
            end
            advance();
        end
        checks++;
        if (got_flow !== want_flow) begin
            errors++;
            $display("[TB] FAIL ldr_flow got=%b want=%b", got_flow, want_flow);
        end
        drive(8'b0000_0000);
        @(negedge clk);
        checks++;
        if (stall_count !== CNT_W'(2)) begin
            errors++;
            $display("[TB] FAIL ldr_count got=%0d want=2", stall_count);
        end
        advance();
    endtask

    task automatic test_indirect();
        logic [3:0] phase_seq;
        logic [3:0] flow_seq;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive((i == 1 || i == 3) ? 8'b0001_1100 : 8'b0001_0100);
            @(negedge clk);
            phase_seq[3-i] = indirect_phase;
            flow_seq[3-i]  = flow_MEMWB & flow_IFID & flow_IDEX & flow_EXMEM;
            advance();
        end
        checks++;
        if (phase_seq !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL ldi_phase got=%b want=0011", phase_seq);
        end
        checks++;
        if (flow_seq !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL ldi_flow got=%b want=0001", flow_seq);
        end
        drive(8'b0000_0000);
        @(negedge clk);
        checks++;
        if (indirect_phase !== 1'b0 || stall_count !== CNT_W'(3)) begin
            errors++;
            $display("[TB] FAIL ldi_end phase=%b cnt=%0d want phase=0 cnt=3", indirect_phase, stall_count);
        end
        advance();
        // Single-cycle memory: pointer cycle then data cycle, then a second op right behind it.
        for (int i = 0; i < 4; i++) begin
            drive(8'b0001_1100);
            @(negedge clk);
            checks++;
            if ({indirect_phase, flow_MEMWB} !== ((i % 2 == 0) ? 2'b00 : 2'b11)) begin
                errors++;
                $display("[TB] FAIL ldi_fast cyc=%0d got=%b want=%b", i,
                         {indirect_phase, flow_MEMWB}, (i % 2 == 0) ? 2'b00 : 2'b11);
            end
            advance();
        end
        drive(8'b0000_0000);
    endtask

    task automatic test_load_use();
        do_reset();
        drive(8'b0110_0010);
        @(negedge clk);
        checks++;
        if ({pc_load, flow_IFID, flush_IDEX, flush_IFID, flow_IDEX} !== 5'b00101) begin
            errors++;
            $display("[TB] FAIL load_use got=%b want=00101",
                     {pc_load, flow_IFID, flush_IDEX, flush_IFID, flow_IDEX});
        end
        advance();
        drive(8'b0110_0000);
        @(negedge clk);
        checks++;
        if (dut_ctl() !== 9'b1_1111_000_0) begin
            errors++;
            $display("[TB] FAIL load_use_next got=%b want=111110000", dut_ctl());
        end
        advance();
    endtask

    task automatic test_branch_priority();
        drive(8'b0100_0011);
        @(negedge clk);
        checks++;
        if (dut_ctl() !== 9'b1_1111_111_0) begin
            errors++;
            $display("[TB] FAIL branch_combo got=%b want=111111110", dut_ctl());
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive((i == 2) ? 8'b0001_1001 : 8'b0001_0001);
            @(negedge clk);
            checks++;
            if ({pc_load, flush_IFID, flush_IDEX, flush_EXMEM} !== ((i == 2) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("[TB] FAIL branch_stall cyc=%0d got=%b want=%b", i,
                         {pc_load, flush_IFID, flush_IDEX, flush_EXMEM}, (i == 2) ? 4'b1111 : 4'b0000);
            end
            advance();
        end
        drive(8'b0000_0000);
    endtask

    task automatic test_reset_mid_indirect();
        do_reset();
        drive(8'b0001_1100);
        advance();
        drive(8'b1001_0100);
        @(negedge clk);
        checks++;
        if (dut_ctl() !== 9'b0_1111_111_1) begin
            errors++;
            $display("[TB] FAIL rst_in_data got=%b want=011111111", dut_ctl());
        end
        advance();
        drive(8'b0000_0000);
        @(negedge clk);
        checks++;
        if (indirect_phase !== 1'b0 || stall_count !== '0 || flow_MEMWB !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid phase=%b cnt=%0d flow=%b want 0 0 1",
                     indirect_phase, stall_count, flow_MEMWB);
        end
        advance();
    endtask

    task automatic test_saturate();
        do_reset();
        drive(8'b0001_0000);
        for (int i = 0; i < CNT_MAX + 6; i++) advance();
        drive(8'b0000_0000);
        @(negedge clk);
        checks++;
        if (stall_count !== CNT_W'(CNT_MAX)) begin
            errors++;
            $display("[TB] FAIL saturate got=%0d want=%0d", stall_count, CNT_MAX);
        end
        advance();
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int i = 0; i < 400; i++) begin
            v = 8'($urandom);
            v[7] = ($urandom_range(0, 24) == 0);
            drive(v);
            @(negedge clk);
            checks++;
            if (dut_ctl() !== model_ctl() || stall_count !== CNT_W'(m_count)) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d in=%b ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                         i, v, dut_ctl(), stall_count, model_ctl(), m_count);
            end
            advance();
        end
        drive(8'b0000_0000);
    endtask

    initial begin
        m_in_op    = 0;
        m_ptr_done = 0;
        m_count    = 0;
        drive(8'b0000_0000);
        test_reset();
        test_plain_load();
        test_indirect();
        test_load_use();
        test_branch_priority();
        test_reset_mid_indirect();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Central stall/flush sequencer for the five-stage LC-3b pipeline. It merges the memory-wait, indirect-access (LDI/STI), load-use and taken-branch conditions into per-register load (flow) and bubble (flush) controls for IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC load. It owns the two-phase indirect memory sequence and a saturating stall-cycle counter. It replaces the single-input combinational stall logic.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- imem_read  in  1  IF stage is requesting an instruction
- imem_resp  in  1  I-side memory returns data this cycle
- dmem_req  in  1  MEM stage holds a load/store (read or write)
- dmem_resp  in  1  D-side memory completes this cycle
- mem_indirect  in  1  MEM instruction is LDI/STI
- load_use  in  1  ID instruction sources the destination of a load in EX
- branch_taken  in  1  MEM stage resolved a taken branch/jump/trap
- pc_load  out  1  PC register loads
- flow_IFID, flow_IDEX, flow_EXMEM, flow_MEMWB  out  1 each  register loads this cycle
- flush_IFID, flush_IDEX, flush_EXMEM  out  1 each  register loads a NOP instead of upstream data (meaningful only with its flow = 1)
- indirect_phase  out  1  0 = pointer fetch, 1 = data access; drives D-address mux
- stall_count  out  CNT_W  cycles with flow_MEMWB = 0 since reset

## Operation
- Indirect FSM states: IDLE, IND_PTR, IND_DATA.
  - IDLE → IND_PTR when mem_indirect & dmem_req.
  - IND_PTR → IND_DATA on dmem_resp. The datapath latches the pointer on that edge.
  - IND_DATA → IDLE on dmem_resp.
  - indirect_phase = (state == IND_DATA).
- mem_stall = (dmem_req & ~dmem_resp) | (state == IND_PTR) | (state == IDLE & mem_indirect & dmem_req).
  - The last term covers the first cycle of the pointer fetch. A dmem_resp in IDLE for an indirect op is the pointer response and does not complete the instruction.
- Priority, highest first. Defaults are all flow = 1, pc_load = 1, all flush = 0.
  1. rst: all flow = 1, all flush = 1, pc_load = 0.
  2. mem_stall: all flow = 0, pc_load = 0. Pipeline is frozen and branch_taken is ignored.
  3. branch_taken: flush_IFID = flush_IDEX = flush_EXMEM = 1. pc_load = 1 loads the target. This overrides load_use and the imem wait.
  4. imem wait (imem_read & ~imem_resp): pc_load = 0, flush_IFID = 1. Downstream stages flow.
  5. load_use: pc_load = 0, flow_IFID = 0, flush_IDEX = 1 (one bubble).
- Priorities 4 and 5 can hold together. Load-use controls IF/ID (hold), flush_IFID = 0, and pc_load = 0.
- stall_count increments when flow_MEMWB = 0 and saturates at all-ones. It clears on rst.

## Timing
- All flow, flush and pc_load outputs are combinational from inputs and state. There is zero added latency.
- State and stall_count update on the rising clk edge.
- Reset values after a rst edge: state IDLE, indirect_phase 0, stall_count 0.
- While rst is high, outputs take the rst row. rst mid-indirect returns the FSM to IDLE on that edge with no further D-side phases.
- An indirect op with single-cycle memory takes 2 cycles in MEM. Cycle 1 is the pointer with all flow = 0. Cycle 2 is data, and the pipeline flows on its dmem_resp.
- For back-to-back indirect ops, the second op's IDLE → IND_PTR begins the cycle after the first returns to IDLE.
- dmem_resp with dmem_req = 0 is ignored.

## Structure
- Add the state enum (IDLE, IND_PTR, IND_DATA) to the shared lc3b_types package.
- Sub-module indirect_fsm contains the state register, transitions and indirect_phase. The top level holds the priority logic and the counter.

## Test plan
- Plain LDR, dmem_resp 3 cycles after dmem_req → all flow = 0 for 2 cycles then 1, stall_count = 2.
- LDI, dmem_resp in cycles 2 and 4 → indirect_phase 0,0,1,1. flow = 0 for cycles 1–3 and 1 in cycle 4. Ends in IDLE.
- load_use = 1 for one cycle, imem hit → pc_load = 0, flow_IFID = 0, flush_IDEX = 1. Next cycle all defaults.
- branch_taken & load_use & imem wait in the same cycle → flush_IFID/IDEX/EXMEM = 1 and pc_load = 1.
- branch_taken while dmem pending → no flush until dmem_resp, then flush asserts in the dmem_resp cycle.
- rst asserted in IND_DATA → next cycle state IDLE, indirect_phase 0, stall_count 0.
- Force 2^CNT_W + 5 stall cycles → stall_count holds at all-ones.
